alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_shifter.sv | 47 ++++
 rtl/alu_exec_unit.sv | 119 +++++++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: funct codes and FSM states.
// Also used by the ALU control decoder so both sides agree on the encodings.
package alu_pkg;

    localparam logic [5:0] ALU_ADDU = 6'b001001;
    localparam logic [5:0] ALU_SUBU = 6'b001010;
    localparam logic [5:0] ALU_AND  = 6'b010001;
    localparam logic [5:0] ALU_SLL  = 6'b100001;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_shifter.sv
// Shift-left-logical engine: one bit per cycle by default, or a single-cycle
// barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amount,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

`ifdef ALU_FAST_SHIFT_EN

    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign data_out   = data_in << amount;
    assign done       = start;

`else

    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else if (start) begin
            work_q <= data_in;
            cnt_q  <= amount;
        end else if (cnt_q != '0) begin
            work_q <= {work_q[WIDTH-2:0], 1'b0};
            cnt_q  <= cnt_q - SHW'(1);
        end
    end

    // Done flags the final step; data_out is the value that step produces.
    assign done     = (cnt_q == SHW'(1));
    assign data_out = {work_q[WIDTH-2:0], 1'b0};

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on request and result sides.
// Define ALU_FAST_SHIFT_EN to make sll single-cycle (no SHIFT state used).
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             accept;
    logic             shift_start;
    logic             shift_done;
    logic [WIDTH-1:0] shift_data;

    assign accept = in_valid && in_ready;

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (shift_start),
        .data_in  (src2),
        .amount   (shamt),
        .done     (shift_done),
        .data_out (shift_data)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        shift_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StDone;
                    illegal_d = 1'b0;
                    case (funct)
                        ALU_ADDU: result_d = src1 + src2;
                        ALU_SUBU: result_d = src1 - src2;
                        ALU_AND:  result_d = src1 & src2;
                        ALU_SLL: begin
`ifdef ALU_FAST_SHIFT_EN
                            result_d = shift_data;
`else
                            if (shamt != '0) begin
                                shift_start = 1'b1;
                                state_d     = StShift;
                            end else begin
                                result_d = src2;
                            end
`endif
                        end
                        default: begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end
                    endcase
                    zero_d = (result_d == '0);
                end
            end
            StShift: begin
                if (shift_done) begin
                    result_d = shift_data;
                    zero_d   = (shift_data == '0);
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (both shift builds).
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  funct;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int n_total;
    int n_bad;
    int lat;
    logic [31:0] held;

`ifdef ALU_FAST_SHIFT_EN
    localparam int SllLat4  = 1;
    localparam int SllLat31 = 1;
`else
    localparam int SllLat4  = 5;
    localparam int SllLat31 = 32;
`endif

    alu_exec_unit #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with in_ready high; returns cycles until out_valid.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, output int latency);
        funct    = f;
        src1     = a;
        src2     = b;
        shamt    = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct    = 6'h3f;
        src1     = $urandom;
        src2     = $urandom;
        shamt    = 5'($urandom);
        latency  = 1;
        while (!out_valid && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        funct     = '0;
        src1      = '0;
        src2      = '0;
        shamt     = '0;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        step();

        // addu wraps to zero
        issue(6'b001001, 32'hFFFF_FFFF, 32'd1, 5'd0, lat);
        check("addu_lat", lat, 32'd1);
        check("addu_result", result, 32'd0);
        check("addu_zero", {31'd0, zero}, 32'd1);
        check("addu_illegal", {31'd0, illegal}, 32'd0);
        step();
        check("addu_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("addu_out_valid_after", {31'd0, out_valid}, 32'd0);

        // subu borrows
        issue(6'b001010, 32'd5, 32'd7, 5'd0, lat);
        check("subu_lat", lat, 32'd1);
        check("subu_result", result, 32'hFFFF_FFFE);
        check("subu_zero", {31'd0, zero}, 32'd0);
        step();
        check("subu_in_ready_after", {31'd0, in_ready}, 32'd1);

        // sll by 4
        issue(6'b100001, 32'hDEAD_0000, 32'h0000_0003, 5'd4, lat);
        check("sll4_lat", lat, SllLat4);
        check("sll4_result", result, 32'h0000_0030);
        check("sll4_illegal", {31'd0, illegal}, 32'd0);
        step();

        // sll by 0 passes src2 through in one cycle
        issue(6'b100001, 32'd0, 32'h0000_ABCD, 5'd0, lat);
        check("sll0_lat", lat, 32'd1);
        check("sll0_result", result, 32'h0000_ABCD);
        step();

        // sll by 31, full length
        issue(6'b100001, 32'd0, 32'h0000_0003, 5'd31, lat);
        check("sll31_lat", lat, SllLat31);
        check("sll31_result", result, 32'h8000_0000);
        check("sll31_zero", {31'd0, zero}, 32'd0);
        step();

        // and with backpressure
        out_ready = 1'b0;
        issue(6'b010001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, lat);
        check("and_lat", lat, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("and_hold_result", result, 32'h00F0_00F0);
            check("and_hold_valid", {31'd0, out_valid}, 32'd1);
            check("and_hold_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        check("and_hold_result_end", result, 32'h00F0_00F0);
        out_ready = 1'b1;
        step();
        check("and_idle_after", {31'd0, in_ready}, 32'd1);
        check("and_out_valid_after", {31'd0, out_valid}, 32'd0);

        // illegal code
        issue(6'b000000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, lat);
        check("ill_lat", lat, 32'd1);
        check("ill_illegal", {31'd0, illegal}, 32'd1);
        check("ill_result", result, 32'd0);
        check("ill_zero", {31'd0, zero}, 32'd1);
        step();

        // reset mid-shift discards the operation
        funct    = 6'b100001;
        src2     = 32'd1;
        shamt    = 5'd31;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("midrst_busy", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) step();
`ifndef ALU_FAST_SHIFT_EN
        check("midrst_not_done", {31'd0, out_valid}, 32'd0);
`endif
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        issue(6'b001001, 32'd2, 32'd3, 5'd0, lat);
        check("post_rst_lat", lat, 32'd1);
        check("post_rst_result", result, 32'd5);
        held = result;
        step();
        for (int i = 0; i < 4; i++) step();
        check("idle_stays_idle", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
